// File: rtl/pong_pkg.sv
// pong_pkg: shared states, geometry constants and coordinate type for the paddle/ball game.
package pong_pkg;
  typedef logic [10:0] coord_t;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_t;
  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;
  localparam coord_t WALL_L = 11'd20;
  localparam coord_t WALL_R = 11'd770;
  localparam coord_t WALL_T = 11'd20;
  localparam coord_t FLOOR_Y = 11'd580;
  localparam coord_t PADDLE_Y = 11'd560;
  localparam coord_t PADDLE_W = 11'd150;
  localparam coord_t BALL = 11'd20;
  localparam coord_t STEP = 11'd4;
  localparam coord_t STEP_MAX = 11'd8;
  localparam coord_t CENTRE_X = 11'd390;
  localparam coord_t CENTRE_Y = 11'd290;
  localparam logic [5:0] SERVE_LAST = 6'd59;
  localparam logic [1:0] LIVES_INIT = 2'd3;
endpackage

// File: rtl/ball_collide.sv
// ball_collide: combinational next-position, reflection and paddle/floor detection for one frame.
module ball_collide
  import pong_pkg::*;
(
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        dx,
  input  logic        dy,
  input  logic [10:0] step,
  input  logic [10:0] paddle_x,
  output logic [10:0] nx,
  output logic [10:0] ny,
  output logic        ndx,
  output logic        ndy,
  output logic        paddle_hit,
  output logic        floor_miss
);
  logic [11:0] pad_r;
  logic overlap, x_lo, x_hi, y_lo;
  always_comb begin
    pad_r = {1'b0, paddle_x} + {1'b0, PADDLE_W};
    overlap = (x + BALL > paddle_x) && ({1'b0, x} < pad_r);
    // dx/dy high means right/down; all tests use additions so nothing underflows
    x_lo = !dx && (x < WALL_L + step);
    x_hi = dx && (x + BALL + step > WALL_R);
    y_lo = !dy && (y < WALL_T + step);
    paddle_hit = dy && (y + BALL + step >= PADDLE_Y) && (y + BALL <= PADDLE_Y) && overlap;
    floor_miss = dy && !paddle_hit && (y + BALL + step > FLOOR_Y);
    nx = floor_miss ? x : x_lo ? WALL_L : x_hi ? WALL_R - BALL : dx ? x + step : x - step;
    ndx = floor_miss ? dx : x_lo ? 1'b1 : x_hi ? 1'b0 : dx;
    ny = floor_miss ? y : y_lo ? WALL_T : paddle_hit ? PADDLE_Y - BALL : dy ? y + step : y - step;
    ndy = floor_miss ? dy : y_lo ? 1'b1 : paddle_hit ? 1'b0 : dy;
  end
endmodule

// File: rtl/ball_game_ctrl.sv
// ball_game_ctrl: game FSM owning ball position, direction, lives and score.
// Define SPEEDUP_EN to raise the ball step after every 8th paddle hit in a serve.
module ball_game_ctrl
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [10:0] paddle_x,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [1:0]  lives,
  output logic [7:0]  score,
  output logic [2:0]  state,
  output logic        hit
);
  state_t state_q, state_d;
  logic [10:0] bx_q, bx_d, by_q, by_d, nx, ny, step;
  logic dx_q, dx_d, dy_q, dy_d, ndx, ndy, p_hit, f_miss, hit_q, hit_d, go_serve;
  logic [1:0] lives_q, lives_d;
  logic [7:0] score_q, score_d;
  logic [5:0] cnt_q, cnt_d;
`ifdef SPEEDUP_EN
  logic [10:0] step_q, step_d;
  logic [2:0] hits_q, hits_d;
  assign step = step_q;
`else
  assign step = STEP;
`endif
  ball_collide u_collide (
    .x(bx_q), .y(by_q), .dx(dx_q), .dy(dy_q), .step(step), .paddle_x(paddle_x),
    .nx(nx), .ny(ny), .ndx(ndx), .ndy(ndy), .paddle_hit(p_hit), .floor_miss(f_miss)
  );
  always_comb begin
    state_d = state_q;
    bx_d = bx_q;
    by_d = by_q;
    dx_d = dx_q;
    dy_d = dy_q;
    lives_d = lives_q;
    score_d = score_q;
    cnt_d = cnt_q;
    hit_d = 1'b0;
    go_serve = 1'b0;
`ifdef SPEEDUP_EN
    step_d = step_q;
    hits_d = hits_q;
`endif
    case (state_q)
      IDLE, OVER: begin
        go_serve = start;
        lives_d = start ? LIVES_INIT : lives_q;
        score_d = start ? 8'd0 : score_q;
      end
      SERVE: if (frame_tick) begin
        state_d = (cnt_q == SERVE_LAST) ? PLAY : SERVE;
        cnt_d = (cnt_q == SERVE_LAST) ? 6'd0 : cnt_q + 6'd1;
      end
      PLAY: if (frame_tick) begin
        bx_d = nx;
        by_d = ny;
        dx_d = ndx;
        dy_d = ndy;
        state_d = f_miss ? MISS : PLAY;
        lives_d = f_miss ? lives_q - 2'(lives_q != 2'd0) : lives_q;
        hit_d = p_hit;
        score_d = p_hit ? score_q + 8'(score_q != 8'hff) : score_q;
`ifdef SPEEDUP_EN
        hits_d = p_hit ? hits_q + 3'd1 : hits_q;
        step_d = (p_hit && hits_q == 3'd7 && step_q < STEP_MAX) ? step_q + 11'd1 : step_q;
`endif
      end
      MISS: begin
        state_d = (lives_q == 2'd0) ? OVER : MISS;
        go_serve = (lives_q != 2'd0);
      end
      default: state_d = IDLE;
    endcase
    if (go_serve) begin
      state_d = SERVE;
      cnt_d = 6'd0;
      bx_d = CENTRE_X;
      by_d = CENTRE_Y;
      dx_d = 1'b1;
      dy_d = 1'b1;
`ifdef SPEEDUP_EN
      step_d = STEP;
      hits_d = 3'd0;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bx_q <= CENTRE_X;
      by_q <= CENTRE_Y;
      dx_q <= 1'b1;
      dy_q <= 1'b1;
      lives_q <= LIVES_INIT;
      score_q <= 8'd0;
      cnt_q <= 6'd0;
      hit_q <= 1'b0;
`ifdef SPEEDUP_EN
      step_q <= STEP;
      hits_q <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      bx_q <= bx_d;
      by_q <= by_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      lives_q <= lives_d;
      score_q <= score_d;
      cnt_q <= cnt_d;
      hit_q <= hit_d;
`ifdef SPEEDUP_EN
      step_q <= step_d;
      hits_q <= hits_d;
`endif
    end
  end
  assign ball_x = bx_q;
  assign ball_y = by_q;
  assign lives = lives_q;
  assign score = score_q;
  assign state = state_q;
  assign hit = hit_q;
endmodule
